// File: rtl/gb_alu_serial.sv
// Multi-cycle Game Boy ALU. Carry-chain ops run LSB-first one slice per cycle;
// every other op completes in a single EXEC cycle. Valid/ready on both sides.
module gb_alu_serial #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SLICE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                op,
  input  logic [DATA_W-1:0]         a,
  input  logic [DATA_W-1:0]         b,
  input  logic [$clog2(DATA_W)-1:0] bit_idx,
  input  logic [3:0]                flags_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         result,
  output logic [3:0]                flags_out
);

  localparam int unsigned NSLICE  = DATA_W / SLICE_W;
  localparam int unsigned CNT_W   = $clog2(NSLICE);
  localparam int unsigned IDX_W   = $clog2(DATA_W);
  localparam int unsigned H_SLICE = ((DATA_W == 8) ? 4 : 12) / SLICE_W - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
  localparam logic [CNT_W-1:0] H_CNT    = CNT_W'(H_SLICE);

  // Codes 0..7 are the slice (carry-chain / bitwise) ops; 26..28 are unassigned.
  typedef enum logic [4:0] {
    OpAdd  = 5'd0,  OpAdc  = 5'd1,  OpSub  = 5'd2,  OpSbc   = 5'd3,
    OpAnd  = 5'd4,  OpXor  = 5'd5,  OpOr   = 5'd6,  OpCp    = 5'd7,
    OpRlc  = 5'd8,  OpRrc  = 5'd9,  OpRl   = 5'd10, OpRr    = 5'd11,
    OpSla  = 5'd12, OpSra  = 5'd13, OpSrl  = 5'd14, OpSwap  = 5'd15,
    OpRlca = 5'd16, OpRrca = 5'd17, OpRla  = 5'd18, OpRra   = 5'd19,
    OpDaa  = 5'd20, OpCpl  = 5'd21, OpScf  = 5'd22, OpCcf   = 5'd23,
    OpPass = 5'd24, OpSpAdj = 5'd25, OpBit = 5'd29, OpRes   = 5'd30,
    OpSet  = 5'd31
  } alu_op_t;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e              state_q, state_d;
  alu_op_t             op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          fl_q, fl_d, flo_q, flo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cy_q, cy_d, h_q, h_d;

  logic                is_slice;
  logic [SLICE_W:0]    add_s, sub_s;
  logic [SLICE_W-1:0]  slice_r;
  logic                slice_co, slice_z;
  logic [DATA_W-1:0]   acc_nxt;
  logic [3:0]          slice_flg;

  logic [DATA_W-1:0]   one_res, rot_res, sp_sum, bmask;
  logic [3:0]          one_flg;
  logic                rot_c, daa_c;
  logic [7:0]          daa_lo;
  logic [4:0]          sp_lo4;
  logic [8:0]          sp_lo8;

  assign is_slice  = (op_q[4:3] == 2'b00);
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;
  assign flags_out = flo_q;

  // One slice of the carry chain; the operands rotate/shift right under it.
  always_comb begin
    add_s = {1'b0, a_q[SLICE_W-1:0]} + {1'b0, b_q[SLICE_W-1:0]} + {{SLICE_W{1'b0}}, cy_q};
    sub_s = {1'b0, a_q[SLICE_W-1:0]} - {1'b0, b_q[SLICE_W-1:0]} - {{SLICE_W{1'b0}}, cy_q};
    slice_r  = a_q[SLICE_W-1:0];
    slice_co = 1'b0;
    case (op_q)
      OpAdd, OpAdc: begin
        slice_r  = add_s[SLICE_W-1:0];
        slice_co = add_s[SLICE_W];
      end
      OpSub, OpSbc, OpCp: begin
        slice_r  = sub_s[SLICE_W-1:0];
        slice_co = sub_s[SLICE_W];
      end
      OpAnd:   slice_r = a_q[SLICE_W-1:0] & b_q[SLICE_W-1:0];
      OpXor:   slice_r = a_q[SLICE_W-1:0] ^ b_q[SLICE_W-1:0];
      OpOr:    slice_r = a_q[SLICE_W-1:0] | b_q[SLICE_W-1:0];
      default: ;
    endcase
    acc_nxt = {slice_r, acc_q[DATA_W-1:SLICE_W]};
    slice_z = (acc_nxt == '0);
    case (op_q)
      OpAdd, OpAdc:      slice_flg = {slice_z, 1'b0, h_q, slice_co};
      OpSub, OpSbc, OpCp: slice_flg = {slice_z, 1'b1, h_q, slice_co};
      OpAnd:             slice_flg = {slice_z, 3'b010};
      default:           slice_flg = {slice_z, 3'b000};
    endcase
  end

  // Single-cycle ops.
  always_comb begin
    rot_res = a_q;
    rot_c   = 1'b0;
    case (op_q)
      OpRlc, OpRlca: begin
        rot_res = {a_q[DATA_W-2:0], a_q[DATA_W-1]};
        rot_c   = a_q[DATA_W-1];
      end
      OpRrc, OpRrca: begin
        rot_res = {a_q[0], a_q[DATA_W-1:1]};
        rot_c   = a_q[0];
      end
      OpRl, OpRla: begin
        rot_res = {a_q[DATA_W-2:0], fl_q[0]};
        rot_c   = a_q[DATA_W-1];
      end
      OpRr, OpRra: begin
        rot_res = {fl_q[0], a_q[DATA_W-1:1]};
        rot_c   = a_q[0];
      end
      OpSla: begin
        rot_res = {a_q[DATA_W-2:0], 1'b0};
        rot_c   = a_q[DATA_W-1];
      end
      OpSra: begin
        rot_res = {a_q[DATA_W-1], a_q[DATA_W-1:1]};
        rot_c   = a_q[0];
      end
      OpSrl: begin
        rot_res = {1'b0, a_q[DATA_W-1:1]};
        rot_c   = a_q[0];
      end
      default: ;
    endcase

    // DAA decisions use the unadjusted byte, as on the original part.
    daa_lo = a_q[7:0];
    daa_c  = fl_q[0];
    if (!fl_q[2]) begin
      if (fl_q[0] || (a_q[7:0] > 8'h99)) begin
        daa_lo = daa_lo + 8'h60;
        daa_c  = 1'b1;
      end
      if (fl_q[1] || (a_q[3:0] > 4'h9)) daa_lo = daa_lo + 8'h06;
    end else begin
      if (fl_q[0]) daa_lo = daa_lo - 8'h60;
      if (fl_q[1]) daa_lo = daa_lo - 8'h06;
    end

    sp_sum = a_q + DATA_W'($signed(b_q[7:0]));
    sp_lo4 = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]};
    sp_lo8 = {1'b0, a_q[7:0]} + {1'b0, b_q[7:0]};
    bmask  = DATA_W'(1) << idx_q;

    one_res = a_q;
    one_flg = fl_q;
    case (op_q)
      OpRlc, OpRrc, OpRl, OpRr, OpSla, OpSra, OpSrl: begin
        one_res = rot_res;
        one_flg = {(rot_res == '0), 2'b00, rot_c};
      end
      OpRlca, OpRrca, OpRla, OpRra: begin
        one_res = rot_res;
        one_flg = {3'b000, rot_c};
      end
      OpSwap: begin
        one_res = {a_q[DATA_W/2-1:0], a_q[DATA_W-1:DATA_W/2]};
        one_flg = {(a_q == '0), 3'b000};
      end
      OpDaa: begin
        one_res[7:0] = daa_lo;
        one_flg      = {(daa_lo == 8'h00), fl_q[2], 1'b0, daa_c};
      end
      OpCpl: begin
        one_res = ~a_q;
        one_flg = {fl_q[3], 2'b11, fl_q[0]};
      end
      OpScf:   one_flg = {fl_q[3], 3'b001};
      OpCcf:   one_flg = {fl_q[3], 2'b00, ~fl_q[0]};
      OpPass:  one_res = b_q;
      OpSpAdj: begin
        one_res = sp_sum;
        one_flg = {2'b00, sp_lo4[4], sp_lo8[8]};
      end
      OpBit:   one_flg = {~a_q[idx_q], 2'b01, fl_q[0]};
      OpRes:   one_res = a_q & ~bmask;
      OpSet:   one_res = a_q | bmask;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    fl_d    = fl_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    h_d     = h_q;
    acc_d   = acc_q;
    res_d   = res_q;
    flo_d   = flo_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = alu_op_t'(op);
          a_d     = a;
          b_d     = b;
          idx_d   = bit_idx;
          fl_d    = flags_in;
          cy_d    = ((op == 5'd1) || (op == 5'd3)) ? flags_in[0] : 1'b0;
          cnt_d   = '0;
          h_d     = 1'b0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_slice) begin
          // After NSLICE rotations a_q is back to the original operand (CP result).
          a_d   = {a_q[SLICE_W-1:0], a_q[DATA_W-1:SLICE_W]};
          b_d   = b_q >> SLICE_W;
          acc_d = acc_nxt;
          cy_d  = slice_co;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == H_CNT) h_d = slice_co;
          if (cnt_q == LAST_CNT) begin
            res_d   = (op_q == OpCp) ? a_d : acc_nxt;
            flo_d   = slice_flg;
            state_d = StDone;
          end
        end else begin
          res_d   = one_res;
          flo_d   = one_flg;
          state_d = StDone;
        end
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      fl_q    <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      h_q     <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      flo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      fl_q    <= fl_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      h_q     <= h_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      flo_q   <= flo_d;
    end
  end

endmodule

// File: tb/tb_gb_alu_serial.sv
// Bench for gb_alu_serial: one 8-bit and one 16-bit instance checked every valid
// cycle against an arithmetic model, plus directed literal vectors.
module tb_gb_alu_serial;

  localparam int SW = 4;
  localparam int OP_ADD = 0, OP_ADC = 1, OP_SUB = 2, OP_SBC = 3, OP_AND = 4, OP_XOR = 5;
  localparam int OP_OR = 6, OP_CP = 7, OP_RLC = 8, OP_RRC = 9, OP_RL = 10, OP_RR = 11;
  localparam int OP_SLA = 12, OP_SRA = 13, OP_SRL = 14, OP_SWAP = 15, OP_RLCA = 16;
  localparam int OP_RRCA = 17, OP_RLA = 18, OP_RRA = 19, OP_DAA = 20, OP_CPL = 21;
  localparam int OP_SCF = 22, OP_CCF = 23, OP_PASS = 24, OP_SPADJ = 25, OP_BIT = 29;
  localparam int OP_RES = 30, OP_SET = 31;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 0, ir8, ov8, or8 = 1;
  logic [4:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, res8;
  logic [2:0] idx8 = 0;
  logic [3:0] fi8 = 0, fo8;

  logic        iv16 = 0, ir16, ov16, or16 = 1;
  logic [4:0]  op16 = 0;
  logic [15:0] a16 = 0, b16 = 0, res16;
  logic [3:0]  idx16 = 0;
  logic [3:0]  fi16 = 0, fo16;

  gb_alu_serial #(.DATA_W(8), .SLICE_W(SW)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .bit_idx(idx8), .flags_in(fi8), .out_valid(ov8), .out_ready(or8), .result(res8),
    .flags_out(fo8)
  );

  gb_alu_serial #(.DATA_W(16), .SLICE_W(SW)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
    .bit_idx(idx16), .flags_in(fi16), .out_valid(ov16), .out_ready(or16), .result(res16),
    .flags_out(fo16)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Returns {Z,N,H,C, result[15:0]}.
  function automatic logic [19:0] model(input int w, input int op, input int a, input int b,
                                        input int idx, input logic [3:0] fl);
    int mask, hb, hm, r, s, ci, msb, lsb, lo, sb;
    bit z, n, h, c, cs;
    mask = (1 << w) - 1;
    hb   = (w == 8) ? 4 : 12;
    hm   = (1 << hb) - 1;
    z = fl[3]; n = fl[2]; h = fl[1]; c = fl[0];
    msb = (a >> (w - 1)) & 1;
    lsb = a & 1;
    r  = a;
    ci = 0;
    cs = 0;
    case (op)
      OP_ADD, OP_ADC: begin
        ci = (op == OP_ADC) ? int'(fl[0]) : 0;
        s = a + b + ci; r = s & mask;
        c = ((s >> w) & 1) != 0; h = ((((a & hm) + (b & hm) + ci) >> hb) & 1) != 0;
        z = (r == 0); n = 0;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        ci = (op == OP_SBC) ? int'(fl[0]) : 0;
        s = a - b - ci; r = s & mask;
        c = (s < 0); h = (((a & hm) - (b & hm) - ci) < 0);
        z = (r == 0); n = 1;
        if (op == OP_CP) r = a;
      end
      OP_AND: begin r = a & b; z = (r == 0); n = 0; h = 1; c = 0; end
      OP_XOR: begin r = a ^ b; z = (r == 0); n = 0; h = 0; c = 0; end
      OP_OR:  begin r = a | b; z = (r == 0); n = 0; h = 0; c = 0; end
      OP_RLC, OP_RLCA: begin r = ((a << 1) | msb) & mask; c = msb != 0; end
      OP_RRC, OP_RRCA: begin r = (a >> 1) | (lsb << (w - 1)); c = lsb != 0; end
      OP_RL, OP_RLA:   begin r = ((a << 1) | int'(fl[0])) & mask; c = msb != 0; end
      OP_RR, OP_RRA:   begin r = (a >> 1) | (int'(fl[0]) << (w - 1)); c = lsb != 0; end
      OP_SLA: begin r = (a << 1) & mask; c = msb != 0; end
      OP_SRA: begin r = (a >> 1) | (msb << (w - 1)); c = lsb != 0; end
      OP_SRL: begin r = a >> 1; c = lsb != 0; end
      OP_SWAP: begin r = ((a << (w / 2)) | (a >> (w / 2))) & mask; z = (r == 0); n = 0; h = 0; c = 0; end
      OP_DAA: begin
        lo = a & 'hFF;
        if (!n) begin
          if (c || lo > 'h99) begin lo += 'h60; cs = 1; end
          if (h || (a & 'hF) > 9) lo += 6;
        end else begin
          if (c) lo -= 'h60;
          if (h) lo -= 6;
        end
        lo &= 'hFF;
        r = (a & ~'hFF) | lo; z = (lo == 0); h = 0; c = c | cs;
      end
      OP_CPL:  begin r = ~a & mask; n = 1; h = 1; end
      OP_SCF:  begin n = 0; h = 0; c = 1; end
      OP_CCF:  begin n = 0; h = 0; c = !fl[0]; end
      OP_PASS: r = b;
      OP_SPADJ: begin
        sb = b & 'hFF;
        if (sb >= 128) sb -= 256;
        r = (a + sb) & mask;
        h = ((((a & 'hF) + (b & 'hF)) >> 4) & 1) != 0;
        c = ((((a & 'hFF) + (b & 'hFF)) >> 8) & 1) != 0;
        z = 0; n = 0;
      end
      OP_BIT: begin z = ((a >> idx) & 1) == 0; n = 0; h = 1; end
      OP_RES: r = a & ~(1 << idx);
      OP_SET: r = (a | (1 << idx)) & mask;
      default: ;
    endcase
    if (op >= OP_RLC && op <= OP_SRL) begin z = (r == 0); n = 0; h = 0; end
    if (op >= OP_RLCA && op <= OP_RRA) begin z = 0; n = 0; h = 0; end
    return {z, n, h, c, 16'(r)};
  endfunction

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    int          acc;
    int          lat;
    bit          seen;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accept, compare on every valid cycle, pop on handshake.
  always @(negedge clk) begin : cmp
    exp_t        e;
    logic [19:0] m;
    if (rst) begin
      q8.delete();
      q16.delete();
    end else begin
      if (ov8) begin
        if (q8.size() == 0) check("spurious_valid8", 32'(ov8), 0);
        else begin
          if (!q8[0].seen) begin
            check("latency8", 32'(cyc - q8[0].acc), 32'(q8[0].lat));
            q8[0].seen = 1'b1;
          end
          check("result8", 32'(res8), 32'(q8[0].res));
          check("flags8", 32'(fo8), 32'(q8[0].fl));
          check("busy_ready8", 32'(ir8), 0);
          if (or8) void'(q8.pop_front());
        end
      end
      if (iv8 && ir8) begin
        m = model(8, int'(op8), int'(a8), int'(b8), int'(idx8), fi8);
        e.res = m[15:0]; e.fl = m[19:16]; e.acc = cyc; e.seen = 1'b0;
        e.lat = (op8 < 5'd8) ? (8 / SW + 1) : 2;
        q8.push_back(e);
      end
      if (ov16) begin
        if (q16.size() == 0) check("spurious_valid16", 32'(ov16), 0);
        else begin
          if (!q16[0].seen) begin
            check("latency16", 32'(cyc - q16[0].acc), 32'(q16[0].lat));
            q16[0].seen = 1'b1;
          end
          check("result16", 32'(res16), 32'(q16[0].res));
          check("flags16", 32'(fo16), 32'(q16[0].fl));
          check("busy_ready16", 32'(ir16), 0);
          if (or16) void'(q16.pop_front());
        end
      end
      if (iv16 && ir16) begin
        m = model(16, int'(op16), int'(a16), int'(b16), int'(idx16), fi16);
        e.res = m[15:0]; e.fl = m[19:16]; e.acc = cyc; e.seen = 1'b0;
        e.lat = (op16 < 5'd8) ? (16 / SW + 1) : 2;
        q16.push_back(e);
      end
    end
  end

  // Inputs are scrambled after accept to prove the DUT registered them.
  task automatic send8(input int o, input int x, input int y, input int i, input int f);
    int n = 0;
    while (!ir8 && n < 60) begin @(posedge clk); #1; n++; end
    op8 = 5'(o); a8 = 8'(x); b8 = 8'(y); idx8 = 3'(i); fi8 = 4'(f); iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; op8 = 5'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    idx8 = 3'($urandom); fi8 = 4'($urandom);
  endtask

  task automatic send16(input int o, input int x, input int y, input int i, input int f);
    int n = 0;
    while (!ir16 && n < 60) begin @(posedge clk); #1; n++; end
    op16 = 5'(o); a16 = 16'(x); b16 = 16'(y); idx16 = 4'(i); fi16 = 4'(f); iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; op16 = 5'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    idx16 = 4'($urandom); fi16 = 4'($urandom);
  endtask

  task automatic wait_idle8();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!ir8 && n < 60);
    check("done_timeout8", 32'(ir8), 1);
  endtask

  task automatic wait_idle16();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!ir16 && n < 60);
    check("done_timeout16", 32'(ir16), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready8", 32'(ir8), 1);
    check("rst_out_valid8", 32'(ov8), 0);
    check("rst_result8", 32'(res8), 0);
    check("rst_flags8", 32'(fo8), 0);
    check("rst_in_ready16", 32'(ir16), 1);
    check("rst_out_valid16", 32'(ov16), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed vectors pin the model.
    check("lit_add8",     32'(model(8, OP_ADD, 'h3A, 'hC6, 0, 4'h0)), 32'h B0000);
    check("lit_sub16",    32'(model(16, OP_SUB, 'h1000, 'h0001, 0, 4'h0)), 32'h 60FFF);
    check("lit_adc16",    32'(model(16, OP_ADC, 'hFFFF, 'h0000, 0, 4'h1)), 32'h B0000);
    check("lit_daa8",     32'(model(8, OP_DAA, 'h3C, 0, 0, 4'h0)), 32'h 00042);
    check("lit_ccf8",     32'(model(8, OP_CCF, 'h55, 0, 0, 4'h9)), 32'h 80055);
    check("lit_bit8",     32'(model(8, OP_BIT, 'h80, 0, 7, 4'h0)), 32'h 20080);
    check("lit_spadj16a", 32'(model(16, OP_SPADJ, 'hFFF8, 'h08, 0, 4'h0)), 32'h 30000);
    check("lit_spadj16b", 32'(model(16, OP_SPADJ, 'h0005, 'hFE, 0, 4'h0)), 32'h 30003);
    check("lit_rr8",      32'(model(8, OP_RR, 'h01, 0, 0, 4'h1)), 32'h 10080);
    check("lit_swap16",   32'(model(16, OP_SWAP, 'h1234, 0, 0, 4'h0)), 32'h 03412);

    // Directed vectors through the DUTs.
    send8(OP_ADD, 'h3A, 'hC6, 0, 0);          wait_idle8();
    check("add8_result", 32'(res8), 32'h00);
    check("add8_flags", 32'(fo8), 32'hB);
    send8(OP_DAA, 'h3C, 0, 0, 0);             wait_idle8();
    send8(OP_CCF, 'h55, 0, 0, 'h9);           wait_idle8();
    send8(OP_BIT, 'h80, 0, 7, 0);             wait_idle8();
    check("bit8_flags", 32'(fo8), 32'h2);
    send16(OP_SUB, 'h1000, 'h0001, 0, 0);     wait_idle16();
    check("sub16_result", 32'(res16), 32'h0FFF);
    check("sub16_flags", 32'(fo16), 32'h6);
    send16(OP_ADC, 'hFFFF, 'h0000, 0, 'h1);   wait_idle16();
    send16(OP_SPADJ, 'hFFF8, 'h0008, 0, 0);   wait_idle16();
    send16(OP_SPADJ, 'h0005, 'h00FE, 0, 0);   wait_idle16();

    // Every opcode, including unassigned ones, at both widths.
    for (int k = 0; k < 32; k++) begin
      send8(k, 'h5A ^ (k * 37), 'h9C + k * 13, k % 8, k % 16);
      wait_idle8();
      send16(k, 'h8F31 ^ (k * 1111), 'h0F0F + k * 4321, k % 16, (k * 7) % 16);
      wait_idle16();
    end

    // Backpressure: hold the result three cycles with in_valid pulses ignored.
    or8 = 1'b0;
    send8(OP_ADD, 'h12, 'h3F, 0, 0);
    n = 0;
    while (!ov8 && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_valid8", 32'(ov8), 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready8", 32'(ir8), 0);
      iv8 = (i == 1); op8 = 5'(OP_SUB); a8 = 8'hFF; b8 = 8'h01;
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after8", 32'(ir8), 1);
    check("bp_valid_after8", 32'(ov8), 0);
    check("bp_result8", 32'(res8), 32'h51);

    // Reset during EXEC slice 1 of a 16-bit ADD.
    send16(OP_ADD, 'h1234, 'h4321, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready16", 32'(ir16), 1);
    check("abort_out_valid16", 32'(ov16), 0);
    check("abort_result16", 32'(res16), 0);
    check("abort_flags16", 32'(fo16), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    send16(OP_ADD, 'h0FFF, 'h0001, 0, 0);     wait_idle16();
    check("post_abort16", 32'(res16), 32'h1000);

    repeat (3) @(posedge clk);
    check("pending8", 32'(q8.size()), 0);
    check("pending16", 32'(q16.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gb_alu_serial.md
Name: gb_alu_serial

Overview:
- Parametrised multi-cycle successor to the combinational Game Boy ALU op set; executes every alu_op_t operation on DATA_W-bit operands.
- Carry-chain ops are processed LSB-first in SLICE_W-bit slices, one slice per cycle, as the original LR35902 nibble ALU does.
- Sits between the CPU decode/regfile and the writeback stage.
- Uses a valid/ready handshake on both sides, so 8-bit register ops and 16-bit HL/SP ops share one datapath.

Parameters:
- DATA_W, 8, operand/result width; legal values 8 or 16.
- SLICE_W, 4, bits processed per EXEC cycle for slice ops; must divide DATA_W and be ≤ 4.
- NSLICE, DATA_W/SLICE_W, derived local parameter, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  5  alu_op_t encoding.
- a  in  DATA_W  operand A (shift/rotate/BIT/RES/SET/DAA/CPL source).
- b  in  DATA_W  operand B.
- bit_idx  in  $clog2(DATA_W)  bit index for BIT/RES/SET.
- flags_in  in  4  flags_t {Z,N,H,C}; current flags, C used as carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_W  operation result.
- flags_out  out  4  flags_t after the operation.

Behaviour:
- Clock/reset: single clock clk; reset rst is asynchronous, active-high.
- On reset: state=IDLE, in_ready=1, out_valid=0, result=0, flags_out=0. All inputs are registered at accept, so later input changes are ignored.
- FSM states: IDLE, EXEC, DONE.
- IDLE→EXEC on in_valid&&in_ready (accept cycle T). in_ready=1 only in IDLE, so no new request is taken while busy or holding.
- EXEC, slice ops (ADD, ADC, SUB, SBC, AND, XOR, OR, CP):
  - One slice per cycle, carry/borrow registered between slices.
  - After NSLICE EXEC cycles go to DONE; out_valid first high at T+NSLICE+1.
- EXEC, all other ops: one EXEC cycle; out_valid first high at T+2.
- DONE: result/flags_out held stable while out_valid=1 and out_ready=0. DONE→IDLE on out_ready, with out_valid low the following cycle. No bypass: a new accept can occur at earliest the cycle after the DONE handshake.
- Half-carry H = carry/borrow out of bit 3 when DATA_W=8, out of bit 11 when DATA_W=16. C = carry/borrow out of MSB. ADC/SBC carry-in = flags_in.C.
- Flags by op:
  - ADD/ADC: Z=(res==0), N=0.
  - SUB/SBC: N=1, H/C are borrows.
  - CP: flags as SUB; result=a.
  - AND: Z, N0 H1 C0.
  - XOR/OR: Z, N0 H0 C0.
  - RLC/RRC/RL/RR/SLA/SRA/SRL on a: C=bit shifted out; RL/RR rotate through flags_in.C; SRA keeps MSB; Z=(res==0), N0 H0.
  - SWAP: exchange upper/lower DATA_W/2 halves; Z, N0 H0 C0.
  - RLCA/RRCA/RLA/RRA: as RLC/RRC/RL/RR but Z=0.
  - DAA: adjusts a[7:0] per N/H/C of flags_in (standard LR35902 rule); upper bits pass through; Z=(a[7:0] result==0), H=0, C set if adjusted by 0x60 or flags_in.C, N unchanged.
  - CPL: res=~a; N1 H1; Z, C unchanged.
  - SCF: C1 N0 H0. CCF: C=~flags_in.C, N0 H0. Both leave Z unchanged and res=a.
  - PASS: res=b, flags=flags_in.
  - SP_ADJ: res=a+sign-extend(b[7:0]) modulo 2^DATA_W; Z0 N0; H/C = carry from bit 3 / bit 7 of the unsigned a[7:0]+b[7:0].
  - BIT: res=a; Z=~a[bit_idx]; N0 H1; C unchanged.
  - RES/SET: res=a with bit_idx cleared/set; flags=flags_in.
  - Unassigned codes 11010, 11011, 11100: res=a, flags=flags_in, 1-cycle path.
- Reset asserted mid-EXEC or in DONE aborts immediately to reset values; the pending result is discarded and never presented.
- in_valid with an illegal bit_idx is impossible by width; no checking is required.

Test Plan:
- DATA_W=8: ADD a=0x3A b=0xC6, out_ready=1 → out_valid at T+3, result 0x00, flags Z1 N0 H1 C1.
- DATA_W=16: SUB a=0x1000 b=0x0001 → out_valid at T+5, result 0x0FFF, flags Z0 N1 H1 C0; ADC 0xFFFF+0x0000 with C=1 → 0x0000, Z1 H1 C1.
- Backpressure: ADD accepted, out_ready=0 for 3 cycles then 1 → result/flags stable, in_ready=0 throughout, in_valid pulses ignored; in_ready=1 the cycle after the handshake.
- DATA_W=8: DAA a=0x3C flags_in N0 H0 C0 → 0x42, Z0 H0 C0; CCF with C=1 → C0, Z unchanged; BIT idx=7 a=0x80 → Z0 H1.
- DATA_W=16: SP_ADJ a=0xFFF8 b=0x08 → 0x0000, Z0 N0 H1 C1; SP_ADJ a=0x0005 b=0xFE → 0x0003, H1 C1.
- Reset asserted during EXEC slice 1 of a 16-bit ADD → out_valid 0, result 0, in_ready 1 immediately; next request completes correctly with its own latency.
